siren: RTL and testbench

- Alarm output stage; consumes the timer's half_hz_enable tick and the main controller's siren request.
- Drives a square-wave speaker signal that alternates between two tones (two-tone siren).
- Tone swaps on every half_hz_enable pulse.
- Time base is scalable for simulation: in the bench, 1 s = 10 clocks.

---
 rtl/siren.sv | 160 ++++++++++++++++
 tb/tb_siren.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/siren.sv
// Two-tone alarm output stage: square-wave speaker that alternates tones on each half_hz_enable tick.
// Optional auto-mute after MAX_SWAPS tone swaps is enabled by defining SIREN_AUTO_MUTE_EN.
module siren #(
    parameter logic [15:0] TONE_A_HALF = 16'd5,
    parameter logic [15:0] TONE_B_HALF = 16'd8,
    parameter logic [7:0]  MAX_SWAPS   = 8'd16
) (
    input  logic clock,
    input  logic reset,
    input  logic siren_on,
    input  logic half_hz_enable,
    output logic speaker,
    output logic tone_sel,
    output logic active,
    output logic muted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TONE_A = 2'd1,
        TONE_B = 2'd2,
        MUTED  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] div_cnt;
    logic [15:0] div_next;
    logic        speaker_next;
    logic [15:0] half_cur;
    logic        terminal;

`ifdef SIREN_AUTO_MUTE_EN
    logic [7:0] swap_cnt;
    logic [7:0] swap_next;
    logic       swap_limit;
`endif

    // Half-period of whichever tone is currently sounding.
    always_comb begin
        half_cur = (state == TONE_B) ? TONE_B_HALF : TONE_A_HALF;
        terminal = (div_cnt == (half_cur - 16'd1));
    end

`ifdef SIREN_AUTO_MUTE_EN
    // An accepted swap that brings the count up to the limit mutes instead of swapping.
    always_comb swap_limit = ((swap_cnt + 8'd1) == MAX_SWAPS);
`endif

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_next   = state;
        div_next     = div_cnt;
        speaker_next = speaker;
`ifdef SIREN_AUTO_MUTE_EN
        swap_next    = swap_cnt;
`endif

        case (state)
            IDLE: begin
                div_next     = 16'd0;
                speaker_next = 1'b0;
`ifdef SIREN_AUTO_MUTE_EN
                swap_next    = 8'd0;
`endif
                if (siren_on) begin
                    state_next = TONE_A;
                end
            end

            TONE_A, TONE_B: begin
                if (!siren_on) begin
                    state_next   = IDLE;
                    div_next     = 16'd0;
                    speaker_next = 1'b0;
`ifdef SIREN_AUTO_MUTE_EN
                    swap_next    = 8'd0;
`endif
                end else if (half_hz_enable) begin
                    // A swap outranks a coincident terminal count: no toggle, speaker level is kept.
                    div_next = 16'd0;
`ifdef SIREN_AUTO_MUTE_EN
                    swap_next = (swap_cnt == MAX_SWAPS) ? swap_cnt : swap_cnt + 8'd1;
                    if (swap_limit) begin
                        state_next   = MUTED;
                        speaker_next = 1'b0;
                    end else begin
                        state_next = (state == TONE_A) ? TONE_B : TONE_A;
                    end
`else
                    state_next = (state == TONE_A) ? TONE_B : TONE_A;
`endif
                end else if (terminal) begin
                    div_next     = 16'd0;
                    speaker_next = ~speaker;
                end else begin
                    div_next = div_cnt + 16'd1;
                end
            end

`ifdef SIREN_AUTO_MUTE_EN
            MUTED: begin
                div_next     = 16'd0;
                speaker_next = 1'b0;
                if (!siren_on) begin
                    state_next = IDLE;
                    swap_next  = 8'd0;
                end
            end
`endif

            default: begin
                state_next   = IDLE;
                div_next     = 16'd0;
                speaker_next = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            div_cnt <= 16'd0;
            speaker <= 1'b0;
        end else begin
            state   <= state_next;
            div_cnt <= div_next;
            speaker <= speaker_next;
        end
    end

`ifdef SIREN_AUTO_MUTE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            swap_cnt <= 8'd0;
        end else begin
            swap_cnt <= swap_next;
        end
    end
`endif

    // Status outputs decode the registered state, so they change on the same edge as the state.
    always_comb begin
        tone_sel = (state == TONE_B);
        active   = (state == TONE_A) || (state == TONE_B);
`ifdef SIREN_AUTO_MUTE_EN
        muted    = (state == MUTED);
`else
        muted    = 1'b0;
`endif
    end

`ifndef SIREN_AUTO_MUTE_EN
    // The swap limit only matters with auto-mute; keep the parameter visibly consumed.
    logic unused_max_swaps;
    assign unused_max_swaps = ^MAX_SWAPS;
`endif

endmodule

// File: tb/tb_siren.sv
// Randomised scoreboard bench for siren: a cycle-level behavioural model queues expected outputs,
// and a monitor compares them one clock-to-output delay after each rising edge.
module tb_siren;

    localparam logic [15:0] HALF_A = 16'd3;
    localparam logic [15:0] HALF_B = 16'd5;
    localparam logic [7:0]  MAXS   = 8'd2;
`ifdef SIREN_AUTO_MUTE_EN
    localparam bit AUTO_MUTE = 1'b1;
`else
    localparam bit AUTO_MUTE = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic siren_on = 1'b0;
    logic half_hz_enable = 1'b0;
    logic speaker;
    logic tone_sel;
    logic active;
    logic muted;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    siren #(
        .TONE_A_HALF(HALF_A),
        .TONE_B_HALF(HALF_B),
        .MAX_SWAPS  (MAXS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .siren_on      (siren_on),
        .half_hz_enable(half_hz_enable),
        .speaker       (speaker),
        .tone_sel      (tone_sel),
        .active        (active),
        .muted         (muted)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got {spk,sel,act,mut}=%b expected %b", name, $time, act, req);
        end
    endtask

    // Reference model: mode 0=idle 1=tone A 2=tone B 3=muted. The speaker level is derived from
    // how long the current tone segment has run and the level it started from.
    int mode        = 0;
    bit start_level = 1'b0;
    int elapsed     = 0;
    int swaps       = 0;

    function automatic bit model_speaker();
        int half;
        if (mode != 1 && mode != 2) return 1'b0;
        half = (mode == 2) ? int'(HALF_B) : int'(HALF_A);
        return start_level ^ bit'((elapsed / half) % 2);
    endfunction

    function automatic logic [3:0] model_out();
        return {model_speaker(), mode == 2, (mode == 1 || mode == 2), mode == 3};
    endfunction

    task automatic model_step(input bit s_on, input bit tick);
        bit lvl;
        case (mode)
            0: if (s_on) begin
                mode = 1; start_level = 1'b0; elapsed = 0; swaps = 0;
            end
            1, 2: begin
                if (!s_on) begin
                    mode = 0;
                end else if (tick) begin
                    lvl = model_speaker();
                    swaps++;
                    if (AUTO_MUTE && swaps == int'(MAXS)) begin
                        mode = 3;
                    end else begin
                        mode = 3 - mode; start_level = lvl; elapsed = 0;
                    end
                end else begin
                    elapsed++;
                end
            end
            default: if (!s_on) mode = 0;
        endcase
    endtask

    // One clock of stimulus: inputs change on the falling edge, expectation for the next rising edge is queued.
    task automatic drive(input bit rst, input bit s_on, input bit tick);
        @(negedge clock);
        reset          = rst;
        siren_on       = s_on;
        half_hz_enable = tick;
        if (!rst) begin
            mode = 0;
            exp_q.push_back(4'b0000);
        end else begin
            model_step(s_on, tick);
            exp_q.push_back(model_out());
        end
    endtask

    initial begin : monitor
        logic [3:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {speaker, tone_sel, active, muted}, e);
            end
        end
    end

    initial begin : stimulus
        int guard;
        // Reset held with the request already high.
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        // Tone A, then swaps, then (with auto-mute) the mute and an ignored third tick.
        repeat (14) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (12) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (8) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b1, 1'b1, 1'b0);
        // siren_on=0 beats a coincident tick in tone B; ticks in idle do nothing.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b1);
        // Tick landing exactly on tone A's terminal count.
        drive(1'b1, 1'b1, 1'b0);
        repeat (2) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (6) drive(1'b1, 1'b1, 1'b0);
        // Asynchronous reset between edges while tone B has the speaker high.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        guard = 0;
        while (!(mode == 2 && model_speaker()) && guard < 50) begin
            drive(1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("reach_toneb_high", {3'b000, guard < 50}, 4'b0001);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {speaker, tone_sel, active, muted}, 4'b0000);
        repeat (2) drive(1'b0, 1'b1, 1'b0);
        // Randomised run with occasional drops of the request and rare resets.
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 29) != 0),
                  ($urandom_range(0, 6) == 0));
        end
        drive(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        check("queue_drained", 4'(exp_q.size()), 4'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
